// File: rtl/tim_pkg.sv
// Shared types and default widths for the multi-channel PWM timer.
package tim_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int CH_NUM_DEF = 4;
    localparam int DT_W_DEF   = 8;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_CENTER = 2'b10,
        MODE_RSVD   = 2'b11
    } cnt_mode_e;

    typedef enum logic [1:0] {
        DT_IDLE   = 2'b00,
        DT_WAIT_P = 2'b01,
        DT_WAIT_N = 2'b10
    } dt_state_e;

endpackage

// File: rtl/tim_dead_time.sv
// One complementary output pair with dead-time insertion, driven by a registered ref.
module tim_dead_time
    import tim_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ref_i,
    input  logic            en_i,
    input  logic [DT_W-1:0] dt_i,
    output logic            out_p_o,
    output logic            out_n_o
);

    dt_state_e       state_q;
    logic [DT_W-1:0] dcnt_q;
    logic            ref_prev_q;
    logic            armed_q;
    logic            out_p_q;
    logic            out_n_q;

    // An unarmed channel (after reset or disable) treats the current ref as a fresh edge.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            state_q    <= DT_IDLE;
            dcnt_q     <= '0;
            ref_prev_q <= 1'b0;
            armed_q    <= 1'b0;
            out_p_q    <= 1'b0;
            out_n_q    <= 1'b0;
        end else if (!armed_q || (ref_i != ref_prev_q)) begin
            armed_q    <= 1'b1;
            ref_prev_q <= ref_i;
            if (dt_i == '0) begin
                out_p_q <= ref_i;
                out_n_q <= !ref_i;
                state_q <= DT_IDLE;
            end else begin
                out_p_q <= 1'b0;
                out_n_q <= 1'b0;
                dcnt_q  <= dt_i;
                state_q <= ref_i ? DT_WAIT_P : DT_WAIT_N;
            end
        end else begin
            case (state_q)
                DT_WAIT_P: begin
                    if (dcnt_q <= DT_W'(1)) begin
                        out_p_q <= 1'b1;
                        state_q <= DT_IDLE;
                    end else begin
                        dcnt_q <= dcnt_q - 1'b1;
                    end
                end
                DT_WAIT_N: begin
                    if (dcnt_q <= DT_W'(1)) begin
                        out_n_q <= 1'b1;
                        state_q <= DT_IDLE;
                    end else begin
                        dcnt_q <= dcnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_p_o = out_p_q;
    assign out_n_o = out_n_q;

endmodule

// File: rtl/tim_pwm_mc.sv
// Multi-channel PWM timer: shared prescaler/counter, shadowed compares, per-channel dead time.
// Define TIM_BREAK_EN to add the brk/brk_clr inputs and brk_flag output that force all outputs low.
module tim_pwm_mc
    import tim_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int CH_NUM = CH_NUM_DEF,
    parameter int DT_W   = DT_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [CNT_W-1:0]        prescaler_i,
    input  logic [1:0]              counter_mode_i,
    input  logic [CNT_W-1:0]        counter_period_i,
    input  logic [CH_NUM*CNT_W-1:0] pulse_i,
    input  logic [CH_NUM-1:0]       ch_en_i,
    input  logic [DT_W-1:0]         dead_time_i,
    output logic [CH_NUM-1:0]       out_p_o,
    output logic [CH_NUM-1:0]       out_n_o,
    output logic                    update_o,
    output logic [CNT_W-1:0]        cnt_o,
    output logic                    dir_o
`ifdef TIM_BREAK_EN
    ,
    input  logic                    brk_i,
    input  logic                    brk_clr_i,
    output logic                    brk_flag_o
`endif
);

    logic [CNT_W-1:0]             pre_cnt_q;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         dir_q, dir_d;
    logic                         upd_q, upd_d;
    logic                         tick;
    logic [CNT_W-1:0]             per_sh_q;
    cnt_mode_e                    mode_sh_q;
    logic [CH_NUM-1:0][CNT_W-1:0] pulse_sh_q;
    logic [CH_NUM-1:0]            ref_q;
    logic [CH_NUM-1:0]            dt_p, dt_n;

    // >= keeps the prescaler from running the long way round if prescaler_i is lowered.
    assign tick = enable_i && (pre_cnt_q >= prescaler_i);

    always_ff @(posedge clk_i) begin
        if (rst_i)         pre_cnt_q <= '0;
        else if (enable_i) pre_cnt_q <= tick ? '0 : pre_cnt_q + 1'b1;
    end

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        upd_d = 1'b0;
        if (tick) begin
            case (mode_sh_q)
                MODE_UP: begin
                    dir_d = 1'b0;
                    if (cnt_q >= per_sh_q) begin
                        cnt_d = '0;
                        upd_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                MODE_DOWN: begin
                    dir_d = 1'b1;
                    // Reload with the period being shadowed in this same clk.
                    if (cnt_q == '0) begin
                        cnt_d = counter_period_i;
                        upd_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                MODE_CENTER: begin
                    if (!dir_q) begin
                        if (cnt_q >= per_sh_q) begin
                            if (per_sh_q <= CNT_W'(1)) begin
                                cnt_d = '0;
                                upd_d = 1'b1;
                            end else begin
                                cnt_d = per_sh_q - 1'b1;
                                dir_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (cnt_q <= CNT_W'(1)) begin
                        cnt_d = '0;
                        dir_d = 1'b0;
                        upd_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            dir_q <= 1'b0;
            upd_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            upd_q <= upd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || upd_d) begin
            per_sh_q   <= counter_period_i;
            mode_sh_q  <= cnt_mode_e'(counter_mode_i);
            pulse_sh_q <= pulse_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || (mode_sh_q == MODE_RSVD)) begin
            ref_q <= '0;
        end else if (enable_i) begin
            for (int i = 0; i < CH_NUM; i++) ref_q[i] <= (cnt_q < pulse_sh_q[i]);
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        tim_dead_time #(.DT_W(DT_W)) u_dt (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .ref_i   (ref_q[g]),
            .en_i    (ch_en_i[g]),
            .dt_i    (dead_time_i),
            .out_p_o (dt_p[g]),
            .out_n_o (dt_n[g])
        );
    end

`ifdef TIM_BREAK_EN
    logic brk_flag_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)          brk_flag_q <= 1'b0;
        else if (brk_i)     brk_flag_q <= 1'b1;
        else if (brk_clr_i) brk_flag_q <= 1'b0;
    end

    assign brk_flag_o = brk_flag_q;
    assign out_p_o    = dt_p & {CH_NUM{~brk_flag_q}};
    assign out_n_o    = dt_n & {CH_NUM{~brk_flag_q}};
`else
    assign out_p_o = dt_p;
    assign out_n_o = dt_n;
`endif

    assign update_o = upd_q;
    assign cnt_o    = cnt_q;
    assign dir_o    = dir_q;

endmodule

// File: doc/tim_pwm_mc.md
Name: tim_pwm_mc

Overview:
Multi-channel PWM timer; next generation of the single-channel complementary-output timer.
- One shared prescaler and counter (up, down or center-aligned) drive CH_NUM compare channels.
- Each channel produces a complementary pair with programmable dead time.
- Period, pulses and mode are shadowed and take effect only on an update event, giving glitch-free reprogramming from the CPU register file.

Parameters:
CNT_W, 16, width of prescaler, counter, period and pulse values
CH_NUM, 4, number of compare channels
DT_W, 8, width of dead-time value (in clk cycles)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  counter run; 0 freezes prescaler and counter
prescaler  in  CNT_W  tick every prescaler+1 clk
counter_mode  in  2  00 up, 01 down, 10 center, 11 reserved
counter_period  in  CNT_W  top value P
pulse  in  CH_NUM*CNT_W  compare value per channel, channel i at [i*CNT_W +: CNT_W]
ch_en  in  CH_NUM  channel output enable
dead_time  in  DT_W  dead time D in clk cycles
out_p  out  CH_NUM  positive PWM outputs
out_n  out  CH_NUM  complementary outputs
update  out  1  one-clk pulse on update event
cnt  out  CNT_W  current counter value
dir  out  1  0 counting up, 1 counting down

Behaviour:
- Reset values: cnt=0, dir=0, prescaler count=0, update=0, out_p=0, out_n=0, internal ref=0.
- While rst=1, shadow regs (period, pulses, mode) load continuously from the inputs. After reset they load only in the clk of an update event.
- Prescaler:
  - Internal pre_cnt increments each clk while enable=1.
  - At pre_cnt==prescaler, tick=1 and pre_cnt is cleared. prescaler=0 gives a tick every clk.
  - Prescaler is not shadowed.
- Counter advances only on tick. Modes:
  - Up: 0..P, then 0. Update at the tick where cnt==P.
  - Down: cnt==0 reloads P, otherwise decrements. Update at the tick where cnt==0; the first tick after reset reloads P and updates.
  - Center: sequence 0..P then P-1..1, then 0 again, giving 2P ticks per period. dir=1 while descending. Update at the tick where cnt==1 and dir==1 (next value 0).
  - Reserved (11): counter holds, ref forced 0, no updates.
  - P==0: cnt stays 0 and update fires every tick in all modes.
- update is asserted in the same clk as the counter register change that completes the period.
- Compare: ref_i registered, ref_i = (cnt < pulse_i). pulse_i==0 means always low; pulse_i>P means always high.
- Dead time, per channel, on a registered output stage:
  - ref rise: out_n falls immediately; out_p rises after D clk.
  - ref fall: out_p falls immediately; out_n rises after D clk.
  - A ref change during a pending delay restarts the delay; both outputs stay low meanwhile.
  - D=0 gives out_n=~out_p with no gap. out_p and out_n are never both 1.
- Latency from cnt change: immediate edge 2 clk; delayed edge 2+D clk.
- ch_en_i=0: out_p_i=out_n_i=0 next clk; dead-time counter cleared. On re-enable, the channel starts as a ref edge occurring then.
- enable=0: prescaler, counter, ref and outputs hold; a pending dead-time counter continues.
- rst mid-period: all state returns to reset values in the next clk regardless of mode.

Optional Feature:
TIM_BREAK_EN
- Compiled in: adds inputs brk and brk_clr and output brk_flag.
  - brk=1 sets brk_flag next clk.
  - While brk_flag=1, all out_p/out_n are forced 0 (counter keeps running).
  - brk_clr=1 clears brk_flag unless brk is still high. brk has priority over brk_clr.
  - rst clears brk_flag.
- Compiled out: ports absent, outputs never forced.

Decomposition:
- Package tim_pkg holds:
  - counter_mode enum (MODE_UP, MODE_DOWN, MODE_CENTER, MODE_RSVD);
  - default width localparams;
  - per-channel dead-time state enum (DT_IDLE, DT_WAIT_P, DT_WAIT_N).
- One sub-module: tim_dead_time, a single channel taking ref, ch_en and D and producing out_p/out_n, instantiated CH_NUM times in a generate loop.

Test Plan:
- prescaler=2, P=10, pulse0=5, mode 00, D=0:
  - tick every 3 clk, update every 33 clk;
  - out_p0 high 15 clk per period, out_n0 its exact complement.
- Same settings, mode 10:
  - update every 60 clk, dir toggles at cnt 10 and 1;
  - out_p0 high 27 clk per period, centred on cnt=0.
- Mode 01, P=10:
  - first tick after reset gives cnt=10 plus update;
  - cnt decrements to 0 then reloads 10.
- Write pulse0=8 mid-period:
  - old duty (5) persists until the next update pulse;
  - new duty (8) applies from the following period.
- D=3, prescaler=0, P=10, pulse=5:
  - out_p rises 5 clk after cnt wraps to 0;
  - both outputs low for exactly 3 clk at each edge; never both high.
- Boundaries:
  - pulse=0 gives out_p stuck 0; pulse=11 gives stuck 1; ch_en=0 gives both 0 within 1 clk.
  - rst mid-period returns cnt=0 and outputs 0.
  - With TIM_BREAK_EN: brk forces all outputs 0 until brk_clr.
